tick_ctrl: RTL
==============

# tick_ctrl

Programmable tick controller for the ALU board's slow-clock path. It generates a one-cycle `tick` enable and a toggling `slow_clk` from the system clock, using a runtime-loadable divisor. It supports three modes: stopped, free-run, and single-step (for stepping the ALU from a debounced button). It sits between the board inputs and the ALU/display logic, and is the single place where slow-clock rate and run/stop policy are decided.

## Interface
Parameters:
- `CNT_W`, 19, width of divisor and period counter
- `DEF_DIV`, 500000, divisor loaded at reset (must fit in `CNT_W`)

Ports:
- `clk`  in  1  system clock; all logic on the rising edge
- `rst`  in  1  synchronous, active-low reset
- `mode`  in  2  00 = stop, 01 = run, 10 = step, 11 = treated as stop
- `step_req`  in  1  step request level; its rising edge is used
- `cfg_valid`  in  1  new divisor offered
- `cfg_div`  in  CNT_W  divisor value, in clk cycles per tick
- `cfg_ready`  out  1  divisor can be accepted this cycle
- `tick`  out  1  one-cycle enable pulse
- `slow_clk`  out  1  toggles on every tick
- `tick_cnt`  out  8  count of ticks issued, wraps 255→0
- `busy`  out  1  high when state is not IDLE

## Operation
- States: IDLE, RUN, STEP.
- Registers:
  - `div_reg` holds the active divisor.
  - `count` runs 0..P-1, where P = max(`div_reg`, 1).
  - `step_q` holds the previous `step_req`.
- IDLE:
  - `count` is held at 0 and no ticks are issued.
  - `mode`=01 → RUN.
  - `mode`=10 and a `step_req` rising edge (`step_req` & ~`step_q`) → STEP.
  - Otherwise stay in IDLE.
- RUN:
  - `count` increments each cycle.
  - When `count`==P-1: `tick` is registered high on the next edge, and `count` goes to 0.
  - `mode`≠01 → IDLE on the next edge, with `count` cleared.
  - A tick scheduled on that same edge is still issued.
- STEP:
  - Counts exactly like RUN.
  - On the edge that issues the tick → IDLE.
  - While in STEP, `mode` changes and `step_req` edges are ignored, so a step always completes with exactly one tick.
- Config handshake:
  - `cfg_ready` = (state ≠ STEP), combinational from state.
  - A transfer occurs on an edge where `cfg_valid` & `cfg_ready` are both high.
  - On that edge, `div_reg` ← `cfg_div` and `count` ← 0.
  - `cfg_div`=0 is accepted and behaves as 1, giving a tick every cycle.
- On every tick edge: `slow_clk` ← ~`slow_clk` and `tick_cnt` ← `tick_cnt`+1 (mod 256).
- `busy` = (state ≠ IDLE).
- Reset (`rst`=0 at an edge):
  - State → IDLE, `div_reg` → `DEF_DIV`, `count` → 0.
  - `tick` → 0, `slow_clk` → 0, `tick_cnt` → 0.
  - `step_q` → 1, so a `step_req` held high through reset does not trigger a step.
  - Output values after reset: `cfg_ready`=1, `busy`=0.
  - Reset mid-STEP or mid-RUN aborts the operation, and no tick is issued on the reset edge.

## Timing
- `tick`, `slow_clk` and `tick_cnt` are registered; `cfg_ready` and `busy` decode from state.
- Free-run cadence, with the state becoming RUN at edge 0:
  - `count` is 0 after edge 0.
  - `tick` is high after edges P, 2P, 3P, … for exactly one cycle each.
  - Example, P=4: ticks after edges 4, 8, 12.
- Step latency: a rising edge of `step_req` is sampled at edge 0, STEP is entered after edge 1, and the tick arrives after edge 1+P.
  - IDLE is re-entered on the tick edge.
  - `busy` is high from edge 1 to edge 1+P.
- Divisor change in RUN:
  - The new period starts from the transfer edge: the first new tick is P_new edges after it.
  - A transfer on the same edge as a scheduled tick still issues that tick (computed from the old `count`), and the counter restarts.
- Config accepted in IDLE on the same edge that RUN is entered: RUN starts with the new divisor and `count`=0.
- `step_req` edges arriving while in RUN or STEP are dropped; they are not queued.

## Test plan
- Reset and default rate:
  - Stimulus: `rst`=0 for 3 cycles, then `rst`=1 with `mode`=01.
  - Required response: outputs are 0, `cfg_ready`=1 and `busy`=0 during reset, and the first tick arrives 500000 edges after RUN is entered.
- Fast run:
  - Stimulus: load `cfg_div`=4 in IDLE, then set `mode`=01.
  - Required response: ticks after edges 4, 8 and 12 of RUN, `slow_clk` toggles at each, and `tick_cnt`=3. After 256 ticks `tick_cnt` wraps to 0.
- Single-step:
  - Stimulus: `cfg_div`=3, `mode`=10, pulse `step_req` for 1 cycle, then pulse it again while `busy`=1.
  - Required response: exactly one tick, 4 edges after the sampled rising edge, and the second pulse is ignored. `cfg_ready`=0 while `busy`=1.
- Reconfigure mid-run:
  - Stimulus: RUN with P=5; at `count`=2 transfer `cfg_div`=2.
  - Required response: no tick at the old slot, and ticks every 2 cycles starting 2 edges after the transfer.
- Edge cases:
  - Stimulus: `cfg_div`=0 with `mode`=01.
  - Required response: tick every cycle.
  - Stimulus: `mode` set to 00 on the same edge as a scheduled tick.
  - Required response: that tick is issued, then IDLE with no further ticks.
- Reset mid-STEP:
  - Stimulus: P=10, step issued, `rst`=0 at STEP cycle 5.
  - Required response: no tick; after reset, IDLE, `div_reg`=`DEF_DIV`, and holding `step_req` high produces no step.

Source files
------------

// File: rtl/tick_ctrl.sv
// Programmable tick controller: divides clk into a one-cycle tick and slow_clk,
// with stop, free-run and single-step modes and a runtime-loadable divisor.
module tick_ctrl #(
    parameter int CNT_W   = 19,
    parameter int DEF_DIV = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             step_req,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             tick,
    output logic             slow_clk,
    output logic [7:0]       tick_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] div_reg;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] last_cnt;
    logic             step_s;
    logic             step_q;
    logic             step_rise;
    logic             at_end;
    logic             fire;
    logic             xfer;

    // A divisor of 0 behaves as 1, so the last count is 0 in both cases.
    always_comb begin
        last_cnt  = (div_reg == '0) ? '0 : div_reg - ONE;
        at_end    = (count == last_cnt);
        fire      = (state != IDLE) && at_end;
        cfg_ready = (state != STEP);
        busy      = (state != IDLE);
        xfer      = cfg_valid && cfg_ready;
        step_rise = step_s && !step_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            div_reg  <= CNT_W'(DEF_DIV);
            count    <= '0;
            step_s   <= 1'b1;
            step_q   <= 1'b1;
            tick     <= 1'b0;
            slow_clk <= 1'b0;
            tick_cnt <= 8'd0;
        end else begin
            step_s <= step_req;
            step_q <= step_s;
            tick   <= fire;
            if (fire) begin
                slow_clk <= ~slow_clk;
                tick_cnt <= tick_cnt + 8'd1;
            end
            unique case (state)
                IDLE: begin
                    count <= '0;
                    if (mode == 2'b01)
                        state <= RUN;
                    else if (mode == 2'b10 && step_rise)
                        state <= STEP;
                end
                RUN: begin
                    count <= at_end ? '0 : count + ONE;
                    if (mode != 2'b01) begin
                        state <= IDLE;
                        count <= '0;
                    end
                end
                STEP: begin
                    // mode and step_req are ignored until the single tick is out
                    count <= at_end ? '0 : count + ONE;
                    if (at_end)
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
            if (xfer) begin
                div_reg <= cfg_div;
                count   <= '0;
            end
        end
    end

endmodule
